// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: sits between the three encoder level registers and the
// three PWM channels. Manual mode passes encoder levels straight through
// (registered). Auto mode walks a small palette of stored colours. It fades
// each channel one LSB per step tick toward the target slot, then dwells for
// a fixed number of ticks before moving to the next written slot.
module rgb_fade_sequencer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned STEP_DIV  = 256,
   parameter int unsigned DWELL     = 512
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             enc0,
   input  logic [WIDTH-1:0]             enc1,
   input  logic [WIDTH-1:0]             enc2,
   input  logic                         store,
   input  logic                         mode,
   output logic [WIDTH-1:0]             level0,
   output logic [WIDTH-1:0]             level1,
   output logic [WIDTH-1:0]             level2,
   output logic [$clog2(NUM_SLOTS)-1:0] slot,
   output logic                         fading,
   output logic [$clog2(NUM_SLOTS):0]   valid_cnt
);

   localparam int unsigned SW = $clog2(NUM_SLOTS);
   localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [PW-1:0] PMAX = PW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DMAX = DW'(DWELL - 1);
   localparam logic [SW:0]   VMAX = (SW+1)'(NUM_SLOTS);

   typedef enum logic [1:0] {IDLE, FADE, HOLD} state_e;

   state_e              state_q, state_d;
   logic [SW-1:0]       slot_q, slot_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic [WIDTH-1:0]    lvl_q [3];
   logic [WIDTH-1:0]    lvl_d [3];

   logic [3*WIDTH-1:0]  pal_q [NUM_SLOTS];
   logic [SW-1:0]       wr_ptr_q;
   logic [SW:0]         valid_q;

   logic [WIDTH-1:0]    tgt [3];
   logic                tick;
   logic                at_tgt;
   logic [SW-1:0]       slot_nx;

   // Palette capture: write pointer wraps, entry count saturates at depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            pal_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         valid_q  <= '0;
      end else if (store) begin
         pal_q[wr_ptr_q] <= {enc2, enc1, enc0};
         wr_ptr_q        <= wr_ptr_q + 1'b1;
         if (valid_q != VMAX) begin
            valid_q <= valid_q + 1'b1;
         end
      end
   end

   // Split the targeted palette word into per-channel targets.
   always_comb begin
      tgt[0] = pal_q[slot_q][WIDTH-1:0];
      tgt[1] = pal_q[slot_q][2*WIDTH-1:WIDTH];
      tgt[2] = pal_q[slot_q][3*WIDTH-1:2*WIDTH];
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         slot_q  <= '0;
         presc_q <= '0;
         dwell_q <= '0;
         lvl_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         presc_q <= presc_d;
         dwell_q <= dwell_d;
         lvl_q   <= lvl_d;
      end
   end

   // Next-state and fade stepping.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      presc_d = presc_q;
      dwell_d = dwell_q;
      lvl_d   = lvl_q;

      tick    = (presc_q == PMAX);
      at_tgt  = (lvl_q[0] == tgt[0]) && (lvl_q[1] == tgt[1]) &&
                (lvl_q[2] == tgt[2]);
      slot_nx = (({1'b0, slot_q} + 1'b1) == valid_q) ? '0 : slot_q + 1'b1;

      if (!mode) begin
         state_d  = IDLE;
         presc_d  = '0;
         dwell_d  = '0;
         lvl_d[0] = enc0;
         lvl_d[1] = enc1;
         lvl_d[2] = enc2;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_q != '0) begin
                  state_d = FADE;
                  slot_d  = '0;
                  presc_d = '0;
               end
            end
            FADE: begin
               // Prescaler restarts on entry to HOLD so the dwell is exactly
               // DWELL*STEP_DIV cycles regardless of where the fade ended.
               if (at_tgt) begin
                  state_d = HOLD;
                  dwell_d = '0;
                  presc_d = '0;
               end else begin
                  presc_d = tick ? '0 : presc_q + 1'b1;
                  if (tick) begin
                     for (int unsigned c = 0; c < 3; c++) begin
                        if (lvl_q[c] < tgt[c]) begin
                           lvl_d[c] = lvl_q[c] + 1'b1;
                        end else if (lvl_q[c] > tgt[c]) begin
                           lvl_d[c] = lvl_q[c] - 1'b1;
                        end
                     end
                  end
               end
            end
            HOLD: begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  if (dwell_q == DMAX) begin
                     state_d = FADE;
                     slot_d  = slot_nx;
                     dwell_d = '0;
                  end else begin
                     dwell_d = dwell_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Registered outputs.
   always_comb begin
      fading    = (state_q == FADE);
      level0    = lvl_q[0];
      level1    = lvl_q[1];
      level2    = lvl_q[2];
      slot      = slot_q;
      valid_cnt = valid_q;
   end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with STEP_DIV=2, DWELL=3, four slots.
module tb_rgb_fade_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] enc0, enc1, enc2;
   logic       store, mode;
   logic [7:0] level0, level1, level2;
   logic [1:0] slot;
   logic       fading;
   logic [2:0] valid_cnt;

   int errors = 0;
   int checks = 0;
   int bad_step = 0;
   int bad_ch2 = 0;
   bit mon2 = 1'b0;

   rgb_fade_sequencer #(
      .WIDTH(8), .NUM_SLOTS(4), .STEP_DIV(2), .DWELL(3)
   ) dut (
      .clk(clk), .reset(reset),
      .enc0(enc0), .enc1(enc1), .enc2(enc2),
      .store(store), .mode(mode),
      .level0(level0), .level1(level1), .level2(level2),
      .slot(slot), .fading(fading), .valid_cnt(valid_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] e0, e1, e2;
      logic       st;
      logic [7:0] x0, x1, x2;
      logic [2:0] xv;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_n(input int n);
      int p0, p1, p2, d;
      for (int i = 0; i < n; i++) begin
         p0 = level0; p1 = level1; p2 = level2;
         step();
         d = int'(level0) - p0; if (d > 1 || d < -1) bad_step++;
         d = int'(level1) - p1; if (d > 1 || d < -1) bad_step++;
         d = int'(level2) - p2; if (d > 1 || d < -1) bad_step++;
         if (mon2 && level2 != 8'h80) bad_ch2++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      step();
   endtask

   task automatic chk_lv(input string name, input int x0, input int x1, input int x2);
      chk({name, ".l0"}, level0, x0);
      chk({name, ".l1"}, level1, x1);
      chk({name, ".l2"}, level2, x2);
   endtask

   task automatic store_rgb(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      enc0 = a; enc1 = b; enc2 = c; store = 1'b1;
      step();
      store = 1'b0;
   endtask

   initial begin
      int prev0;
      tbl[0] = '{8'h10, 8'h20, 8'h30, 1'b0, 8'h10, 8'h20, 8'h30, 3'd0};
      tbl[1] = '{8'hFF, 8'h00, 8'h80, 1'b0, 8'hFF, 8'h00, 8'h80, 3'd0};
      tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 8'h00, 8'hFF, 8'h01, 3'd1};
      tbl[3] = '{8'hAA, 8'h55, 8'hC3, 1'b1, 8'hAA, 8'h55, 8'hC3, 3'd2};
      tbl[4] = '{8'h01, 8'h02, 8'h03, 1'b1, 8'h01, 8'h02, 8'h03, 3'd3};
      tbl[5] = '{8'h7F, 8'h80, 8'hFE, 1'b1, 8'h7F, 8'h80, 8'hFE, 3'd4};
      tbl[6] = '{8'h11, 8'h22, 8'h33, 1'b1, 8'h11, 8'h22, 8'h33, 3'd4};

      reset = 1'b1; mode = 1'b0; store = 1'b0;
      enc0 = 8'h00; enc1 = 8'h00; enc2 = 8'h00;
      #12;
      chk_lv("rst", 0, 0, 0);
      chk("rst.fading", fading, 0);
      chk("rst.valid", valid_cnt, 0);
      chk("rst.slot", slot, 0);
      reset = 1'b0;
      step();

      // Manual passthrough table; the later stores fill and wrap the palette.
      prev0 = 0;
      for (int i = 0; i < 7; i++) begin
         enc0 = tbl[i].e0; enc1 = tbl[i].e1; enc2 = tbl[i].e2; store = tbl[i].st;
         #1;
         chk($sformatf("tbl%0d.nocomb", i), level0, prev0);
         step();
         store = 1'b0;
         chk_lv($sformatf("tbl%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].x2);
         chk($sformatf("tbl%0d.valid", i), valid_cnt, tbl[i].xv);
         chk($sformatf("tbl%0d.fading", i), fading, 0);
         prev0 = tbl[i].x0;
      end

      // Slot 0 now holds the fifth store {33,22,11}; fade up from zero.
      enc0 = 8'h00; enc1 = 8'h00; enc2 = 8'h00;
      step();
      chk_lv("wrap.zero", 0, 0, 0);
      mode = 1'b1;
      run_n(35);
      chk_lv("wrap.e35", 17, 17, 17);
      run_n(34);
      chk_lv("wrap.e69", 17, 34, 34);
      run_n(34);
      chk_lv("wrap.e103", 17, 34, 51);
      chk("wrap.fading103", fading, 1);
      run_n(1);
      chk("wrap.fading104", fading, 0);

      // Single entry {30,20,10}: timed fade, 6-cycle hold, re-target slot 0.
      mode = 1'b0;
      do_reset();
      store_rgb(8'd10, 8'd20, 8'd30);
      enc0 = 8'h00; enc1 = 8'h00; enc2 = 8'h00;
      step();
      chk("one.valid", valid_cnt, 1);
      chk_lv("one.start", 0, 0, 0);
      mode = 1'b1;
      for (int k = 1; k <= 69; k++) begin
         int n, xf;
         step();
         n = (k - 1) / 2;
         xf = ((k >= 1 && k <= 61) || k == 68) ? 1 : 0;
         chk($sformatf("one.fading.e%0d", k), fading, xf);
         chk($sformatf("one.l0.e%0d", k), level0, (n < 10) ? n : 10);
         chk($sformatf("one.l2.e%0d", k), level2, (n < 30) ? n : 30);
         chk($sformatf("one.slot.e%0d", k), slot, 0);
      end

      // Two entries: slot 0 -> 1 -> 0, decrements stop at zero.
      mode = 1'b0;
      do_reset();
      store_rgb(8'hFF, 8'h00, 8'h80);
      store_rgb(8'h00, 8'hFF, 8'h80);
      enc0 = 8'h00; enc1 = 8'h00; enc2 = 8'h00;
      step();
      chk("two.valid", valid_cnt, 2);
      chk_lv("two.start", 0, 0, 0);
      mode = 1'b1;
      bad_step = 0; bad_ch2 = 0;
      run_n(257);
      chk_lv("two.e257", 128, 0, 128);
      mon2 = 1'b1;
      run_n(254);
      chk_lv("two.e511", 255, 0, 128);
      chk("two.fading511", fading, 1);
      run_n(1);
      chk("two.fading512", fading, 0);
      chk("two.slot512", slot, 0);
      run_n(6);
      chk("two.slot518", slot, 1);
      chk("two.fading518", fading, 1);
      run_n(510);
      chk_lv("two.e1028", 0, 255, 128);
      run_n(1);
      chk("two.fading1029", fading, 0);
      run_n(6);
      chk("two.slot1035", slot, 0);
      chk("two.fading1035", fading, 1);
      run_n(510);
      chk_lv("two.e1545", 255, 0, 128);
      run_n(4);
      chk_lv("two.hold", 255, 0, 128);
      chk("two.bad_step", bad_step, 0);
      chk("two.ch2_stays", bad_ch2, 0);
      mon2 = 1'b0;

      // Mode drop mid-fade, then resume from the manual levels.
      mode = 1'b0;
      do_reset();
      store_rgb(8'd100, 8'd100, 8'd100);
      enc0 = 8'h00; enc1 = 8'h00; enc2 = 8'h00;
      step();
      mode = 1'b1;
      run_n(21);
      chk_lv("sw.e21", 10, 10, 10);
      chk("sw.fading21", fading, 1);
      mode = 1'b0; enc0 = 8'd50; enc1 = 8'd60; enc2 = 8'd70;
      step();
      chk_lv("sw.e22", 50, 60, 70);
      chk("sw.fading22", fading, 0);
      mode = 1'b1; enc0 = 8'h00; enc1 = 8'h00; enc2 = 8'h00;
      step();
      chk_lv("sw.e23", 50, 60, 70);
      chk("sw.fading23", fading, 1);
      run_n(2);
      chk_lv("sw.e25", 51, 61, 71);
      run_n(98);
      chk_lv("sw.e123", 100, 100, 100);
      chk("sw.fading123", fading, 1);
      run_n(1);
      chk("sw.fading124", fading, 0);
      run_n(2);

      // Asynchronous reset in HOLD, between clock edges.
      #3;
      reset = 1'b1;
      #1;
      chk_lv("areset", 0, 0, 0);
      chk("areset.fading", fading, 0);
      chk("areset.valid", valid_cnt, 0);
      chk("areset.slot", slot, 0);
      #2;
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk($sformatf("empty.fading%0d", k), fading, 0);
         chk_lv($sformatf("empty%0d", k), 0, 0, 0);
      end
      chk("empty.valid", valid_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
